// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code decoder: prefix FSM states,
// protocol prefix bytes and modifier key make codes.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK
   } prefix_state_t;

   localparam logic [7:0] CODE_EXT    = 8'hE0;
   localparam logic [7:0] CODE_BRK    = 8'hF0;
   localparam logic [7:0] CODE_BAT_OK = 8'hAA;
   localparam logic [7:0] CODE_ACK    = 8'hFA;

   localparam logic [7:0] CODE_LSHIFT = 8'h12;
   localparam logic [7:0] CODE_RSHIFT = 8'h59;
   localparam logic [7:0] CODE_CAPS   = 8'h58;

   typedef struct packed {
      logic       hit;
      logic [7:0] ch;
   } ascii_lookup_t;

endpackage

// File: rtl/ps2_char_fifo.sv
// Small synchronous character FIFO. Pointers carry one extra wrap bit so that
// full and empty are told apart without a separate counter. A push into a
// full FIFO is only taken when a pop happens in the same cycle; otherwise it
// is reported on the drop output.
module ps2_char_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] out_data,
   output logic             not_empty,
   output logic             drop
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign not_empty = (wr_ptr != rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop    = pop && not_empty;
   assign do_push   = push && (!full || do_pop);
   assign drop      = push && !do_push;
   assign out_data  = not_empty ? mem[rd_ptr[AW-1:0]] : '0;

   // Pointer update; both may advance together, leaving occupancy unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage array; contents are meaningless while empty so it needs no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/ps2_code_decoder.sv
// PS/2 set-2 scan code to ASCII decoder with an output character FIFO.
// Optional feature: define PS2_SHIFT_EN to track shift and caps-lock and
// produce uppercase letters and shifted digit-row symbols.
module ps2_code_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] scan_code,
   input  logic       scan_valid,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] drop_cnt
);

   logic          scan_valid_q;
   logic          strobe_q;
   logic [7:0]    code_q;
   prefix_state_t state_q;
   logic          push_q;
   logic [7:0]    push_data_q;
   logic          fifo_drop;
   logic          shift_on;
   logic          upper_on;
   logic [4:0]    letter_num;
   logic [3:0]    digit_num;
   logic [7:0]    digit_sym;
   ascii_lookup_t lookup;

`ifdef PS2_SHIFT_EN
   logic lshift_q;
   logic rshift_q;
   logic caps_q;

   assign shift_on = lshift_q || rshift_q;
   assign upper_on = shift_on ^ caps_q;
`else
   assign shift_on = 1'b0;
   assign upper_on = 1'b0;
`endif

   // Catch the 0->1 edge of the receiver's ready level and latch its byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_valid_q <= 1'b0;
         strobe_q     <= 1'b0;
         code_q       <= 8'h00;
      end else begin
         scan_valid_q <= scan_valid;
         strobe_q     <= scan_valid && !scan_valid_q;
         code_q       <= scan_code;
      end
   end

   // Scan-code table: letters and digits are indexed from 1 so zero means miss.
   always_comb begin
      letter_num = 5'd0;
      digit_num  = 4'd0;
      lookup     = '0;
      case (code_q)
         8'h1C: letter_num = 5'd1;
         8'h32: letter_num = 5'd2;
         8'h21: letter_num = 5'd3;
         8'h23: letter_num = 5'd4;
         8'h24: letter_num = 5'd5;
         8'h2B: letter_num = 5'd6;
         8'h34: letter_num = 5'd7;
         8'h33: letter_num = 5'd8;
         8'h43: letter_num = 5'd9;
         8'h3B: letter_num = 5'd10;
         8'h42: letter_num = 5'd11;
         8'h4B: letter_num = 5'd12;
         8'h3A: letter_num = 5'd13;
         8'h31: letter_num = 5'd14;
         8'h44: letter_num = 5'd15;
         8'h4D: letter_num = 5'd16;
         8'h15: letter_num = 5'd17;
         8'h2D: letter_num = 5'd18;
         8'h1B: letter_num = 5'd19;
         8'h2C: letter_num = 5'd20;
         8'h3C: letter_num = 5'd21;
         8'h2A: letter_num = 5'd22;
         8'h1D: letter_num = 5'd23;
         8'h22: letter_num = 5'd24;
         8'h35: letter_num = 5'd25;
         8'h1A: letter_num = 5'd26;
         8'h45: digit_num  = 4'd1;
         8'h16: digit_num  = 4'd2;
         8'h1E: digit_num  = 4'd3;
         8'h26: digit_num  = 4'd4;
         8'h25: digit_num  = 4'd5;
         8'h2E: digit_num  = 4'd6;
         8'h36: digit_num  = 4'd7;
         8'h3D: digit_num  = 4'd8;
         8'h3E: digit_num  = 4'd9;
         8'h46: digit_num  = 4'd10;
         8'h29: lookup     = {1'b1, 8'h20};
         8'h5A: lookup     = {1'b1, 8'h0D};
         8'h66: lookup     = {1'b1, 8'h08};
         8'h0D: lookup     = {1'b1, 8'h09};
         default: ;
      endcase
      case (digit_num)
         4'd1:    digit_sym = 8'h29;
         4'd2:    digit_sym = 8'h21;
         4'd3:    digit_sym = 8'h40;
         4'd4:    digit_sym = 8'h23;
         4'd5:    digit_sym = 8'h24;
         4'd6:    digit_sym = 8'h25;
         4'd7:    digit_sym = 8'h5E;
         4'd8:    digit_sym = 8'h26;
         4'd9:    digit_sym = 8'h2A;
         4'd10:   digit_sym = 8'h28;
         default: digit_sym = 8'h00;
      endcase
      if (letter_num != 5'd0) begin
         lookup.hit = 1'b1;
         lookup.ch  = (upper_on ? 8'h40 : 8'h60) + {3'b000, letter_num};
      end else if (digit_num != 4'd0) begin
         lookup.hit = 1'b1;
         lookup.ch  = shift_on ? digit_sym : (8'h2F + {4'b0000, digit_num});
      end
   end

   // Prefix FSM: only final codes seen from IDLE are make codes that may print.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         push_q      <= 1'b0;
         push_data_q <= 8'h00;
`ifdef PS2_SHIFT_EN
         lshift_q    <= 1'b0;
         rshift_q    <= 1'b0;
         caps_q      <= 1'b0;
`endif
      end else begin
         push_q <= 1'b0;
         if (strobe_q) begin
            case (state_q)
               ST_IDLE: begin
                  if (code_q == CODE_EXT) begin
                     state_q <= ST_EXT;
                  end else if (code_q == CODE_BRK) begin
                     state_q <= ST_BRK;
                  end else begin
                     state_q <= ST_IDLE;
                     if (code_q != CODE_BAT_OK && code_q != CODE_ACK && lookup.hit) begin
                        push_q      <= 1'b1;
                        push_data_q <= lookup.ch;
                     end
`ifdef PS2_SHIFT_EN
                     if (code_q == CODE_LSHIFT) lshift_q <= 1'b1;
                     if (code_q == CODE_RSHIFT) rshift_q <= 1'b1;
                     if (code_q == CODE_CAPS)   caps_q   <= !caps_q;
`endif
                  end
               end
               ST_EXT: begin
                  state_q <= (code_q == CODE_BRK) ? ST_EXT_BRK : ST_IDLE;
               end
               ST_BRK: begin
                  state_q <= ST_IDLE;
`ifdef PS2_SHIFT_EN
                  if (code_q == CODE_LSHIFT) lshift_q <= 1'b0;
                  if (code_q == CODE_RSHIFT) rshift_q <= 1'b0;
`endif
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Count characters lost to overflow, sticking at the top value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= 8'h00;
      end else if (fifo_drop && drop_cnt != 8'hFF) begin
         drop_cnt <= drop_cnt + 8'h01;
      end
   end

   ps2_char_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_q),
      .push_data (push_data_q),
      .pop       (out_ready),
      .out_data  (out_data),
      .not_empty (out_valid),
      .drop      (fifo_drop)
   );

endmodule

// File: tb/tb_ps2_code_decoder.sv
// Scoreboard bench for ps2_code_decoder: a keyboard-level model predicts the
// characters for each scan byte, a monitor pops and compares on every accept.
module tb_ps2_code_decoder;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] scan_code = 8'h00;
   logic       scan_valid = 1'b0;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] drop_cnt;

   int  sb[$];
   int  compared = 0;
   int  mismatched = 0;
   int  exp_drop = 0;
   bit  hold_ready = 1'b0;
   bit  rand_ready = 1'b0;
   bit  prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;

   bit m_ext, m_brk, m_lsh, m_rsh, m_caps;

   byte unsigned lcode [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   byte unsigned dcode [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   byte unsigned misc [9]   = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'hAA, 8'hFA, 8'h12, 8'h59, 8'h58};
   string dsym = ")!@#$%^&*(";

   always #10 clk = ~clk;

   ps2_code_decoder #(.FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .scan_code  (scan_code),
      .scan_valid (scan_valid),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .drop_cnt   (drop_cnt)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Keyboard model: returns the printed character, or -1 when nothing prints.
   function automatic int modelChar(input byte unsigned c);
      bit was_make, was_break, shift;
      if (!m_ext && !m_brk && c == 8'hE0) begin m_ext = 1'b1; return -1; end
      if (!m_brk && c == 8'hF0) begin m_brk = 1'b1; return -1; end
      was_make  = !m_ext && !m_brk;
      was_break = m_brk && !m_ext;
      m_ext = 1'b0;
      m_brk = 1'b0;
`ifdef PS2_SHIFT_EN
      if (was_break && c == 8'h12) m_lsh = 1'b0;
      if (was_break && c == 8'h59) m_rsh = 1'b0;
      if (was_make && c == 8'h12) begin m_lsh = 1'b1; return -1; end
      if (was_make && c == 8'h59) begin m_rsh = 1'b1; return -1; end
      if (was_make && c == 8'h58) begin m_caps = !m_caps; return -1; end
`endif
      if (!was_make) return -1;
      shift = m_lsh || m_rsh;
      for (int i = 0; i < 26; i++)
         if (lcode[i] == c) return (shift ^ m_caps) ? 'h41 + i : 'h61 + i;
      for (int i = 0; i < 10; i++)
         if (dcode[i] == c) return shift ? int'(dsym[i]) : 'h30 + i;
      case (c)
         8'h29:   return 'h20;
         8'h5A:   return 'h0D;
         8'h66:   return 'h08;
         8'h0D:   return 'h09;
         default: return -1;
      endcase
   endfunction

   task automatic applyStimulus(input byte unsigned c, input int hold, input int gap);
      int ch;
      ch = modelChar(c);
      if (ch >= 0) begin
         if (hold_ready && sb.size() >= DEPTH) begin
            if (exp_drop < 255) exp_drop++;
         end else begin
            sb.push_back(ch);
         end
      end
      @(posedge clk);
      #1;
      scan_code  = c;
      scan_valid = 1'b1;
      repeat (hold) @(posedge clk);
      #1;
      scan_valid = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   task automatic waitDrain(input string name);
      for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
      repeat (6) @(negedge clk);
      checkOutput(name, sb.size(), 0);
   endtask

   // Monitor: compare each accepted byte with the scoreboard head.
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_stall && out_valid) checkOutput("hold_stable", out_data, prev_data);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL unexpected_byte: got 0x%0h, expected none", out_data);
            end else begin
               checkOutput("out_byte", out_data, sb.pop_front());
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Random consumer back-pressure during the random phase.
   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         out_ready = ($urandom_range(7) != 0);
      end
   end

   initial begin
      int r;
      byte unsigned c;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_out_data", out_data, 0);
      checkOutput("reset_drop_cnt", drop_cnt, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Make 0x1C with latency check, then its break.
      sb.push_back(modelChar(8'h1C));
      @(posedge clk);
      #1;
      scan_code  = 8'h1C;
      scan_valid = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checkOutput("latency_n2", out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("latency_n3", out_valid, 1);
      @(posedge clk);
      #1;
      scan_valid = 1'b0;
      repeat (2) @(posedge clk);
      applyStimulus(8'hF0, 1, 2);
      applyStimulus(8'h1C, 1, 2);
      waitDrain("make_break_a");

      // Extended key make and break are silent, then space prints.
      applyStimulus(8'hE0, 1, 2);
      applyStimulus(8'h75, 1, 2);
      applyStimulus(8'hE0, 1, 2);
      applyStimulus(8'hF0, 1, 2);
      applyStimulus(8'h75, 1, 2);
      applyStimulus(8'h29, 1, 2);
      waitDrain("extended_then_space");

      // Ready level held for many cycles is a single byte.
      applyStimulus(8'h5A, 100, 3);
      waitDrain("long_level");

      // Overflow with the consumer stalled.
      out_ready  = 1'b0;
      hold_ready = 1'b1;
      repeat (6) applyStimulus(8'h16, 1, 2);
      repeat (6) @(posedge clk);
      @(negedge clk);
      checkOutput("ovf_drop_cnt", drop_cnt, exp_drop);
      checkOutput("ovf_out_valid", out_valid, 1);
      checkOutput("ovf_head", out_data, 8'h31);
      hold_ready = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      waitDrain("ovf_drain");

      // Randomised byte stream against the model.
      rand_ready = 1'b1;
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(9);
         if (r <= 3)      c = lcode[$urandom_range(25)];
         else if (r <= 5) c = dcode[$urandom_range(9)];
         else if (r == 6) c = 8'hE0;
         else if (r == 7) c = 8'hF0;
         else if (r == 8) c = misc[$urandom_range(8)];
         else             c = 8'($urandom_range(255));
         applyStimulus(c, $urandom_range(3, 1), $urandom_range(5, 2));
      end
      rand_ready = 1'b0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      waitDrain("rand_drain");
      checkOutput("rand_drop_cnt", drop_cnt, exp_drop);

`ifdef PS2_SHIFT_EN
      // Return modifiers to a known state, then exercise shift and caps.
      applyStimulus(8'h00, 1, 2);
      applyStimulus(8'hF0, 1, 2);
      applyStimulus(8'h12, 1, 2);
      applyStimulus(8'hF0, 1, 2);
      applyStimulus(8'h59, 1, 2);
      if (m_caps) applyStimulus(8'h58, 1, 2);
      waitDrain("shift_prep");
      applyStimulus(8'h12, 1, 2);
      applyStimulus(8'h1C, 1, 2);
      applyStimulus(8'hF0, 1, 2);
      applyStimulus(8'h12, 1, 2);
      applyStimulus(8'h1C, 1, 2);
      applyStimulus(8'h58, 1, 2);
      applyStimulus(8'h1C, 1, 2);
      applyStimulus(8'h58, 1, 2);
      waitDrain("shift_caps");
`endif

      // Reset in the middle of a break prefix with bytes queued.
      applyStimulus(8'h00, 1, 2);
      waitDrain("pre_reset_idle");
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      applyStimulus(8'h1C, 1, 2);
      applyStimulus(8'h29, 1, 2);
      applyStimulus(8'hF0, 1, 2);
      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput("pre_reset_valid", out_valid, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb.delete();
      exp_drop = 0;
      m_ext = 0; m_brk = 0; m_lsh = 0; m_rsh = 0; m_caps = 0;
      @(negedge clk);
      checkOutput("midreset_out_valid", out_valid, 0);
      checkOutput("midreset_drop_cnt", drop_cnt, 0);
      checkOutput("midreset_out_data", out_data, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      applyStimulus(8'h1C, 1, 2);
      waitDrain("post_reset_a");
      checkOutput("post_reset_drop_cnt", drop_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
